// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit multiplexed 7-segment display.
// Walks digits 0..3, enabling each one for SCAN_DIV cycles and then
// blanking all of them for GUARD_CYC cycles. Incoming data is
// double-buffered so a new value only appears at a frame boundary.
// Optional leading-zero blanking is applied to the displayed value.
//
// Output timing: every output is a register loaded from a decode of the
// current scan state. The visible outputs therefore trail the scan state
// by one clock. The shadow-to-active transfer fires in the cycle where
// o_frame is visible, so a load in that same cycle can bypass the buffer.

module seg_scan_ctrl #(
   parameter int SCAN_DIV  = 50000,
   parameter int GUARD_CYC = 500
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [15:0] i_data,
   input  logic [3:0]  i_dp,
   input  logic        i_load,
   input  logic        i_lz_en,
   output logic [3:0]  o_sel_bcd,
   output logic [7:0]  o_digit,
   output logic        o_dp_n,
   output logic        o_frame
);

   localparam int MAX_CYC = (SCAN_DIV > GUARD_CYC) ? SCAN_DIV : GUARD_CYC;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);

   typedef enum logic {
      ST_ON    = 1'b0,
      ST_GUARD = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             frameSet;

   logic [15:0]      shadowData_q, shadowData_d;
   logic [3:0]       shadowDp_q, shadowDp_d;
   logic [15:0]      activeData_q, activeData_d;
   logic [3:0]       activeDp_q, activeDp_d;
   logic             transfer;

   logic [3:0]       zeroFrom;
   logic [3:0]       blank;
   logic [3:0]       curNibble;

   logic [3:0]       sel_q, sel_d;
   logic [7:0]       digit_q, digit_d;
   logic             dpN_q, dpN_d;
   logic             frame_q;

   // Scan state register: state, digit index and the shared slot counter.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_ON;
         idx_q   <= 2'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

   // Slot sequencing: ON for SCAN_DIV cycles, GUARD for GUARD_CYC cycles, then the next digit.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q + CNT_W'(1);
      frameSet = 1'b0;
      case (state_q)
         ST_ON: begin
            if (cnt_q == ON_LAST) begin
               state_d = ST_GUARD;
               cnt_d   = '0;
            end
         end
         ST_GUARD: begin
            if (cnt_q == GUARD_LAST) begin
               state_d = ST_ON;
               cnt_d   = '0;
               idx_d   = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  frameSet = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_ON;
            cnt_d   = '0;
         end
      endcase
   end

   // Buffer update: loads land in the shadow; the frame cycle moves shadow to active, bypassed by a coincident load.
   always_comb begin
      transfer     = frame_q;
      shadowData_d = i_load ? i_data : shadowData_q;
      shadowDp_d   = i_load ? i_dp   : shadowDp_q;
      activeData_d = activeData_q;
      activeDp_d   = activeDp_q;
      if (transfer) begin
         activeData_d = i_load ? i_data : shadowData_q;
         activeDp_d   = i_load ? i_dp   : shadowDp_q;
      end
   end

   // Shadow and active data registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         shadowData_q <= '0;
         shadowDp_q   <= '0;
         activeData_q <= '0;
         activeDp_q   <= '0;
      end else begin
         shadowData_q <= shadowData_d;
         shadowDp_q   <= shadowDp_d;
         activeData_q <= activeData_d;
         activeDp_q   <= activeDp_d;
      end
   end

   // Leading-zero detection: a digit blanks when it and all higher nibbles are zero and its own DP is off.
   always_comb begin
      zeroFrom[3] = (activeData_d[15:12] == 4'h0);
      zeroFrom[2] = zeroFrom[3] && (activeData_d[11:8] == 4'h0);
      zeroFrom[1] = zeroFrom[2] && (activeData_d[7:4]  == 4'h0);
      zeroFrom[0] = zeroFrom[1] && (activeData_d[3:0]  == 4'h0);
      blank[0]    = 1'b0;
      blank[1]    = i_lz_en && zeroFrom[1] && !activeDp_d[1];
      blank[2]    = i_lz_en && zeroFrom[2] && !activeDp_d[2];
      blank[3]    = i_lz_en && zeroFrom[3] && !activeDp_d[3];
   end

   // Output decode for the current scan state; GUARD turns everything off but holds the digit value.
   always_comb begin
      sel_d     = 4'b1111;
      digit_d   = digit_q;
      dpN_d     = 1'b1;
      curNibble = activeData_d[{idx_q, 2'b00} +: 4];
      if (state_q == ST_ON) begin
         digit_d = {4'h0, curNibble};
         if (!blank[idx_q]) begin
            sel_d[idx_q] = 1'b0;
            dpN_d        = ~activeDp_d[idx_q];
         end
      end
   end

   // Registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sel_q   <= 4'b1111;
         digit_q <= 8'h00;
         dpN_q   <= 1'b1;
         frame_q <= 1'b0;
      end else begin
         sel_q   <= sel_d;
         digit_q <= digit_d;
         dpN_q   <= dpN_d;
         frame_q <= frameSet;
      end
   end

   assign o_sel_bcd = sel_q;
   assign o_digit   = digit_q;
   assign o_dp_n    = dpN_q;
   assign o_frame   = frame_q;

endmodule
